// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, sizing helper and default widths for the UART TX arbiter.
package uart_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
  localparam int N_REQ_DEF   = 4;
  localparam int MAX_LEN_DEF = 64;
  localparam int ID_W        = clog2(N_REQ_DEF);
  localparam int CNT_W       = clog2(MAX_LEN_DEF + 1);
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search upward from ptr_i+1 with wrap-around.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_i,
  input  logic [clog2(N_REQ)-1:0] ptr_i,
  output logic                    any_req_o,
  output logic [clog2(N_REQ)-1:0] pick_id_o
);
  localparam int IW = clog2(N_REQ);
  logic [IW-1:0] idx;
  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    any_req_o = |req_i;
    pick_id_o = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_i) + k) % N_REQ);
      pick_id_o = req_i[idx] ? idx : pick_id_o;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of the UART TX FIFO write port.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DBIT    = 8,
  parameter int MAX_LEN = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DBIT-1:0]   req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DBIT-1:0]         w_data_o,
  output logic                    wr_uart_o,
  input  logic                    tx_full_i,
  output logic                    busy_o,
  output logic [clog2(N_REQ)-1:0] grant_id_o,
  output logic                    pkt_done_o,
  output logic                    len_err_o,
  output logic [clog2(N_REQ)-1:0] err_id_o
);
  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(MAX_LEN + 1);
  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, lerr_q, lerr_d;
  logic          any_req, xfer, accept, last, at_cap;
  logic [IW-1:0] pick_id;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .any_req_o (any_req),
    .pick_id_o (pick_id)
  );
  assign xfer        = state_q == ST_XFER;
  assign accept      = xfer & req_valid_i[grant_q] & ~tx_full_i;
  assign last        = req_last_i[grant_q];
  assign at_cap      = (cnt_q + CW'(1)) == CW'(MAX_LEN);
  assign busy_o      = xfer;
  assign wr_uart_o   = accept;
  assign req_ready_o = (xfer & ~tx_full_i) ? (N_REQ'(1) << grant_q) : '0;
  assign w_data_o    = xfer ? req_data_i[grant_q*DBIT +: DBIT] : '0;
  assign grant_id_o  = grant_q;
  assign pkt_done_o  = done_q;
  assign len_err_o   = lerr_q;
  assign err_id_o    = err_q;
  // A last byte at the cap counts as a normal completion, not a cut.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    if (!xfer) begin
      if (any_req) begin
        state_d = ST_XFER;
        grant_d = pick_id;
        cnt_d   = '0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);
      if (last | at_cap) begin
        state_d = ST_IDLE;
        ptr_d   = grant_q;
        done_d  = last;
        lerr_d  = ~last;
        err_d   = last ? err_q : grant_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      err_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-based reference model of packet round-robin arbitration, checked every cycle.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int ML = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*DB-1:0] req_data = '0;
  logic [DB-1:0] w_data;
  logic wr_uart, tx_full = 1'b0, busy, pkt_done, len_err;
  logic [1:0] grant_id, err_id;
  uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready), .w_data_o(w_data),
    .wr_uart_o(wr_uart), .tx_full_i(tx_full), .busy_o(busy), .grant_id_o(grant_id),
    .pkt_done_o(pkt_done), .len_err_o(len_err), .err_id_o(err_id)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, start = 0;
  int gap_pct = 0, full_mode = 0, full_pct = 0;
  byte unsigned qd[N][$];
  bit ql[N][$];
  bit m_busy, m_done, m_lerr;
  int m_gid, m_ptr, m_cnt, m_err;
  int wcyc[$], wdat[$], wid[$], dcyc[$], did[$], lcyc[$], lid[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int r, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      qd[r].push_back(8'(base + k));
      ql[r].push_back(k == n - 1);
    end
  endtask

  task automatic clear_logs();
    wcyc.delete(); wdat.delete(); wid.delete();
    dcyc.delete(); did.delete(); lcyc.delete(); lid.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit has;
      has = qd[i].size() > 0;
      req_valid[i] = has && ($urandom_range(0, 99) >= gap_pct);
      req_data[i*DB +: DB] = has ? qd[i][0] : 8'h00;
      req_last[i] = has ? ql[i][0] : 1'b0;
    end
    tx_full = (full_mode == 2) ? ($urandom_range(0, 99) < full_pct) : (full_mode == 1);
  endtask

  // Compare against the model at the falling edge, then advance the model by one clock.
  task automatic cycle();
    bit exp_wr, lst;
    int best, bd, d;
    drive();
    @(negedge clk);
    exp_wr = m_busy && req_valid[m_gid] && !tx_full;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("req_ready", 32'(req_ready), (m_busy && !tx_full) ? (1 << m_gid) : 0);
    chk("wr_uart", 32'(wr_uart), 32'(exp_wr));
    chk("w_data", 32'(w_data), m_busy ? 32'(req_data[m_gid*DB +: DB]) : 0);
    chk("grant_id", 32'(grant_id), m_gid);
    chk("pkt_done", 32'(pkt_done), 32'(m_done));
    chk("len_err", 32'(len_err), 32'(m_lerr));
    chk("err_id", 32'(err_id), m_err);
    if (wr_uart) begin wcyc.push_back(cyc); wdat.push_back(int'(w_data)); wid.push_back(int'(grant_id)); end
    if (pkt_done) begin dcyc.push_back(cyc); did.push_back(int'(grant_id)); end
    if (len_err) begin lcyc.push_back(cyc); lid.push_back(int'(err_id)); end
    m_done = 0;
    m_lerr = 0;
    if (!m_busy) begin
      best = -1;
      bd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr - 1 + 2 * N) % N;
        if (req_valid[i] && d < bd) begin bd = d; best = i; end
      end
      if (best >= 0) begin m_busy = 1; m_gid = best; m_cnt = 0; end
    end else if (exp_wr && qd[m_gid].size() > 0) begin
      lst = ql[m_gid][0];
      void'(qd[m_gid].pop_front());
      void'(ql[m_gid].pop_front());
      m_cnt++;
      if (lst) begin m_busy = 0; m_done = 1; m_ptr = m_gid; end
      else if (m_cnt == ML) begin m_busy = 0; m_lerr = 1; m_err = m_gid; m_ptr = m_gid; end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_busy = 0; m_done = 0; m_lerr = 0; m_gid = 0; m_ptr = N - 1; m_cnt = 0; m_err = 0;
    for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); end
    req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_wr", 32'(wr_uart), 0);
      chk("rst_wdata", 32'(w_data), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_done", 32'(pkt_done), 0);
      chk("rst_lerr", 32'(len_err), 0);
      chk("rst_errid", 32'(err_id), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    bit pend;
    k = 0;
    pend = 1;
    while (pend && k < budget) begin
      pend = m_busy;
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) pend = 1;
      if (pend) begin cycle(); k++; end
    end
    chk("drain_budget", 32'(k < budget), 1);
    repeat (2) cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Single requester, three bytes.
    clear_logs(); start = cyc;
    push(1, 3, 'h41);
    drain(20);
    chk("t1_nwr", wcyc.size(), 3);
    if (wcyc.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk("t1_data", wdat[k], 'h41 + k);
        chk("t1_id", wid[k], 1);
        chk("t1_cyc", wcyc[k], start + 1 + k);
      end
    chk("t1_ndone", dcyc.size(), 1);
    if (dcyc.size() == 1) chk("t1_done_cyc", dcyc[0], start + 4);
    // Contention from reset: 0, 2, 3 with two 2-byte packets each.
    do_reset();
    clear_logs(); start = cyc;
    push(0, 2, 'h10); push(0, 2, 'h14);
    push(2, 2, 'h20); push(2, 2, 'h24);
    push(3, 2, 'h30); push(3, 2, 'h34);
    drain(60);
    chk("t2_ndone", dcyc.size(), 6);
    if (dcyc.size() == 6) begin
      chk("t2_order0", did[0], 0); chk("t2_order1", did[1], 2);
      chk("t2_order2", did[2], 3); chk("t2_order3", did[3], 0);
    end
    if (wcyc.size() == 12)
      for (int k = 0; k < 4; k++) chk("t2_first_cyc", wcyc[2*k], start + 1 + 3*k);
    // Backpressure: five stalled cycles after the first byte.
    clear_logs();
    push(1, 3, 'h50);
    full_mode = 0; repeat (2) cycle();
    full_mode = 1; repeat (5) cycle();
    full_mode = 0;
    drain(20);
    chk("t3_nwr", wcyc.size(), 3);
    if (wcyc.size() == 3) begin
      chk("t3_gap", wcyc[1] - wcyc[0], 6);
      chk("t3_data", wdat[1], 'h51);
    end
    // Length cap, requester 2 alone: cut after 4, re-granted for the rest.
    clear_logs();
    push(2, 6, 'h60);
    drain(40);
    chk("t4_nwr", wcyc.size(), 6);
    chk("t4_nlerr", lcyc.size(), 1);
    if (lcyc.size() == 1 && wcyc.size() == 6) begin
      chk("t4_errid", lid[0], 2);
      chk("t4_lerr_cyc", lcyc[0], wcyc[3] + 1);
      chk("t4_regrant_cyc", wcyc[4], lcyc[0] + 1);
    end
    chk("t4_ndone", did.size(), 1);
    if (did.size() == 1) chk("t4_done_id", did[0], 2);
    // Length cap with a competitor: requester 0 wins after the cut.
    clear_logs();
    push(2, 6, 'h70);
    repeat (2) cycle();
    push(0, 1, 'h80);
    drain(40);
    if (wcyc.size() == 7) chk("t4b_next", wdat[4], 'h80);
    else chk("t4b_nwr", wcyc.size(), 7);
    if (did.size() == 2) begin chk("t4b_d0", did[0], 0); chk("t4b_d1", did[1], 2); end
    // Last byte exactly at the cap.
    clear_logs();
    push(1, 4, 'h90);
    drain(20);
    chk("t5_nlerr", lcyc.size(), 0);
    chk("t5_ndone", dcyc.size(), 1);
    // Reset in the middle of a 5-byte packet.
    clear_logs();
    push(1, 5, 'hA0);
    repeat (3) cycle();
    drive();
    #2;
    chk("t6_pre_wr", 32'(wr_uart), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_wr_drop", 32'(wr_uart), 0);
    chk("t6_busy_drop", 32'(busy), 0);
    chk("t6_ready_drop", 32'(req_ready), 0);
    do_reset();
    clear_logs();
    push(0, 1, 'hB0); push(1, 1, 'hB1);
    drain(20);
    if (did.size() == 2) begin chk("t6_first", did[0], 0); chk("t6_second", did[1], 1); end
    else chk("t6_ndone", did.size(), 2);
    // Randomized traffic with bubbles and backpressure.
    gap_pct = 20; full_mode = 2; full_pct = 25;
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (qd[i].size() < 8 && $urandom_range(0, 9) == 0)
          push(i, $urandom_range(1, 7), $urandom_range(0, 255));
      cycle();
    end
    gap_pct = 0; full_mode = 0;
    drain(2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
